img_stream_src: RTL and testbench
=================================

Name: img_stream_src

Overview:
- Parametrised, synthesizable raster pixel source. Replaces file-driven image injection with a block that reads a frame buffer through a 1-cycle-latency memory read port.
- Emits a valid/ready pixel stream with linear address and per-pixel hsync/vsync markers.
- Supports configurable frame size, pixel width, inter-line blanking and multi-frame playback.
- Sits between the frame memory and the pupil-detection processing chain.

Parameters:
IMG_W, 320, pixels per line (>=2)
IMG_H, 240, lines per frame (>=2)
PIX_W, 8, pixel data width in bits
ADDR_W, 20, address width; IMG_W*IMG_H <= 2^ADDR_W required
H_BLANK, 0, idle cycles inserted after the last read of each line (0 = none)
NUM_FRAMES, 1, frames per start command; 0 = continuous until reset

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin playback; sampled only in IDLE, ignored otherwise
mem_rd_en  output  1  memory read strobe
mem_rd_addr  output  ADDR_W  memory read address
mem_rd_data  input  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
pix_valid  output  1  output pixel valid
pix_ready  input  1  downstream accept; transfer when pix_valid & pix_ready
pix_data  output  PIX_W  pixel value
pix_addr  output  ADDR_W  linear address of pix_data (y*IMG_W+x)
hsync  output  1  high with the last pixel of each line (qualified by pix_valid)
vsync  output  1  high with the last pixel of each frame (qualified by pix_valid)
busy  output  1  high from the cycle after start is accepted until done
done  output  1  1-cycle pulse after the last pixel of the last frame is accepted

Behaviour:
- Reset: every output 0; FSM in IDLE; counters, buffer and in-flight flag cleared. Applies mid-frame; in-flight read data is discarded.
- FSM states:
  - IDLE: start=1 -> READ.
  - READ: issues reads.
  - BLANK: H_BLANK-cycle down-count with no reads, then READ.
  - DRAIN: all reads for the command issued; wait for the last output accept, then pulse done -> IDLE.
- READ -> BLANK after the read of x=IMG_W-1, only if H_BLANK>0. READ -> DRAIN after the last read of frame NUM_FRAMES.
- Read issue: mem_rd_en = (state==READ) && (buf_count + inflight < 3). Address counter starts at 0, increments per issued read, wraps to 0 after IMG_W*IMG_H-1.
- Read data is written into a 3-entry FIFO on the cycle after mem_rd_en, together with its address and its x/y end flags.
- pix_valid = FIFO not empty. pix_data, pix_addr, hsync and vsync come from the FIFO head.
- Push and pop in the same cycle leave the count unchanged. The FIFO can never overflow by construction; overflow is an assertion failure.
- Latency: start sampled at edge E0 -> mem_rd_en high in the following cycle -> pix_valid high 2 cycles after E0.
- Throughput: with pix_ready held 1 and H_BLANK=0, one pixel per cycle, no bubbles after the first.
- Backpressure: pix_ready=0 holds the head stable (data, addr, markers). Reads stall once the FIFO plus in-flight read reaches 3. No loss, no duplication.
- Frame counter increments on acceptance of a vsync pixel. With NUM_FRAMES=0, never enters DRAIN; busy stays high.
- done pulses the cycle after the final accept; busy falls in that same cycle. A start asserted in the same cycle as done is ignored; start is accepted from the next cycle.

Optional Feature:
- Macro TEST_PATTERN_EN.
- When defined: adds input pattern_sel (1 bit, sampled at start acceptance, held for the command).
  - pattern_sel=1: no memory reads (mem_rd_en stays 0). FIFO is filled internally with pix_data = (x + y) truncated to PIX_W, using the same timing, blanking and markers.
  - pattern_sel=0: memory mode.
- When not defined: port absent; memory mode only.

Test Plan:
- IMG_W=4, IMG_H=3, NUM_FRAMES=1, ready=1, mem[i]=i+16 -> 12 consecutive pixels with data 16..27 and addr 0..11. hsync at addr 3, 7, 11; vsync only at 11. First pix_valid 2 cycles after start. done 1 cycle after last accept.
- Same config, pix_ready low for 5 cycles after pixel 2, then alternating 1/0 -> sequence unchanged. mem_rd_en stalls with buf_count+inflight never exceeding 3. Head stable while stalled.
- H_BLANK=2 -> exactly 2 cycles with mem_rd_en=0 after each 4th read. hsync/vsync placement unchanged.
- NUM_FRAMES=2 -> 24 pixels, addresses 0..11 then 0..11, vsync twice, single done pulse. start held high during busy has no effect.
- reset asserted after 5th accept -> all outputs 0 next cycle. New start replays from addr 0 with no stale data.
- TEST_PATTERN_EN, pattern_sel=1, IMG_W=4, IMG_H=3 -> pix_data 0,1,2,3,1,2,3,4,2,3,4,5. mem_rd_en never asserted.

Source files
------------

// File: rtl/img_stream_src.sv
// Raster pixel source: reads a frame buffer through a 1-cycle-latency port and emits a valid/ready pixel stream.
// Define TEST_PATTERN_EN to add pattern_sel, which replaces memory data with an internal (x+y) pattern.

module img_stream_src #(
    parameter int unsigned IMG_W      = 320,
    parameter int unsigned IMG_H      = 240,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned H_BLANK    = 0,
    parameter int unsigned NUM_FRAMES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              busy,
    output logic              done
);

    localparam int unsigned X_W        = $clog2(IMG_W);
    localparam int unsigned Y_W        = $clog2(IMG_H);
    localparam int unsigned SUM_W      = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int unsigned FRAME_W    = (NUM_FRAMES <= 2) ? 1 : $clog2(NUM_FRAMES);
    localparam int unsigned LAST_FRAME = (NUM_FRAMES == 0) ? 0 : NUM_FRAMES - 1;
    localparam int unsigned BLANK_W    = (H_BLANK <= 2) ? 1 : $clog2(H_BLANK);
    localparam int unsigned BLANK_LOAD = (H_BLANK == 0) ? 0 : H_BLANK - 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_BLANK, S_DRAIN} state_t;

    typedef struct packed {
        logic [PIX_W-1:0]  data;
        logic [ADDR_W-1:0] addr;
        logic              hs;
        logic              vs;
    } entry_t;

    state_t              state, state_nxt;
    logic                done_set;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [ADDR_W-1:0]   addr;
    logic [FRAME_W-1:0]  rd_frame, out_frame;
    logic [BLANK_W-1:0]  blank_cnt;
    logic                start_ok, issue, line_end, frame_end, last_read;
    logic                rd_last_frame, out_last_frame, accept, head_last;
    logic                inflight, pipe_hs, pipe_vs;
    logic [ADDR_W-1:0]   pipe_addr;
    entry_t              fifo_mem [0:2];
    entry_t              head, push_word;
    logic [1:0]          wr_ptr, rd_ptr, count;
`ifdef TEST_PATTERN_EN
    logic                pat_mode;
    logic [PIX_W-1:0]    pipe_pat;
`endif

    assign line_end       = (x == X_W'(IMG_W - 1));
    assign frame_end      = line_end && (y == Y_W'(IMG_H - 1));
    assign rd_last_frame  = (NUM_FRAMES != 0) && (rd_frame == FRAME_W'(LAST_FRAME));
    assign out_last_frame = (NUM_FRAMES != 0) && (out_frame == FRAME_W'(LAST_FRAME));
    assign start_ok       = (state == S_IDLE) && start && !done;
    // At most three pixels may be buffered or in flight at any time.
    assign issue          = (state == S_READ) && (({1'b0, count} + {2'b0, inflight}) < 3'd3);
    assign last_read      = issue && frame_end && rd_last_frame;
    assign head           = fifo_mem[rd_ptr];
    assign pix_valid      = (count != 2'd0);
    assign accept         = pix_valid && pix_ready;
    assign head_last      = accept && head.vs && out_last_frame;

`ifdef TEST_PATTERN_EN
    assign mem_rd_en = issue && !pat_mode;
`else
    assign mem_rd_en = issue;
`endif
    assign mem_rd_addr = addr;
    assign pix_data    = pix_valid ? head.data : '0;
    assign pix_addr    = pix_valid ? head.addr : '0;
    assign hsync       = pix_valid && head.hs;
    assign vsync       = pix_valid && head.vs;

    // FIFO write word: returned read data joined with the address and markers captured at issue.
    always_comb begin
        push_word      = '0;
        push_word.addr = pipe_addr;
        push_word.hs   = pipe_hs;
        push_word.vs   = pipe_vs;
`ifdef TEST_PATTERN_EN
        push_word.data = pat_mode ? pipe_pat : mem_rd_data;
`else
        push_word.data = mem_rd_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_READ;
            S_READ: begin
                if (last_read)                                 state_nxt = S_DRAIN;
                else if (issue && line_end && (H_BLANK != 0))  state_nxt = S_BLANK;
            end
            S_BLANK: if (blank_cnt == '0) state_nxt = S_READ;
            S_DRAIN: begin
                if (head_last) begin
                    state_nxt = S_IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            rd_frame  <= '0;
            out_frame <= '0;
            blank_cnt <= '0;
            inflight  <= 1'b0;
            pipe_addr <= '0;
            pipe_hs   <= 1'b0;
            pipe_vs   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < 3; i++) fifo_mem[i] <= '0;
`ifdef TEST_PATTERN_EN
            pat_mode  <= 1'b0;
            pipe_pat  <= '0;
`endif
        end else begin
            busy      <= (state_nxt != S_IDLE);
            done      <= done_set;
            inflight  <= issue;
            pipe_addr <= addr;
            pipe_hs   <= line_end;
            pipe_vs   <= frame_end;
`ifdef TEST_PATTERN_EN
            pipe_pat  <= PIX_W'(SUM_W'(x) + SUM_W'(y));
            if (start_ok) pat_mode <= pattern_sel;
`endif
            if (issue) begin
                x    <= line_end ? '0 : x + X_W'(1);
                addr <= frame_end ? '0 : addr + ADDR_W'(1);
                if (line_end) y <= frame_end ? '0 : y + Y_W'(1);
                if (frame_end) rd_frame <= rd_last_frame ? '0 : rd_frame + FRAME_W'(1);
            end
            if (accept && head.vs) out_frame <= out_last_frame ? '0 : out_frame + FRAME_W'(1);
            if ((state == S_READ) && (state_nxt == S_BLANK)) blank_cnt <= BLANK_W'(BLANK_LOAD);
            else if ((state == S_BLANK) && (blank_cnt != '0)) blank_cnt <= blank_cnt - BLANK_W'(1);
            if (inflight) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (accept) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            case ({inflight, accept})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A push into a full FIFO without a matching pop would lose a pixel.
    assert property (@(posedge clk) disable iff (reset) !(inflight && !accept && (count == 2'd3)));

endmodule

// File: tb/tb_img_stream_src.sv
// Bench for img_stream_src: three 4x3 instances (plain, H_BLANK=2, NUM_FRAMES=2) checked against a pixel scoreboard.
// Define TEST_PATTERN_EN to also exercise the internal pattern mode.

module tb_img_stream_src;

    localparam int unsigned W = 4, H = 3, PW = 8, AW = 8, NPIX = 12;

    typedef struct packed {
        logic [PW-1:0] data;
        logic [AW-1:0] addr;
        logic          hs;
        logic          vs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    start, ready, rd_en, valid, hs, vs, busy, done;
    logic [AW-1:0] rd_addr [3];
    logic [PW-1:0] data [3];
    logic [AW-1:0] paddr [3];
`ifdef TEST_PATTERN_EN
    logic [2:0]    pat_sel;
`endif
    exp_t          sb [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [PW-1:0] mem_q;
        img_stream_src #(
            .IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW),
            .H_BLANK((g == 1) ? 2 : 0), .NUM_FRAMES((g == 2) ? 2 : 1)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start[g]),
`ifdef TEST_PATTERN_EN
            .pattern_sel(pat_sel[g]),
`endif
            .mem_rd_en(rd_en[g]), .mem_rd_addr(rd_addr[g]), .mem_rd_data(mem_q),
            .pix_valid(valid[g]), .pix_ready(ready[g]), .pix_data(data[g]), .pix_addr(paddr[g]),
            .hsync(hs[g]), .vsync(vs[g]), .busy(busy[g]), .done(done[g])
        );
        // Frame memory: mem[i] = i + 16, data one cycle after the strobe, garbage otherwise.
        always @(posedge clk) mem_q <= rd_en[g] ? PW'(rd_addr[g] + AW'(16)) : PW'(8'hEE);
    end

    task automatic push_frames(input int nf, input bit pat);
        exp_t e;
        for (int f = 0; f < nf; f++)
            for (int i = 0; i < int'(NPIX); i++) begin
                e.data = pat ? PW'(i / W + i % W) : PW'(i + 16);
                e.addr = AW'(i);
                e.hs   = ((i % W) == W - 1);
                e.vs   = (i == NPIX - 1);
                sb.push_back(e);
            end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = '0; ready = '0;
`ifdef TEST_PATTERN_EN
        pat_sel = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({rd_en[k], valid[k], hs[k], vs[k], busy[k], done[k], data[k], paddr[k], rd_addr[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d got %h required 0", k,
                         {rd_en[k], valid[k], hs[k], vs[k], busy[k], done[k], data[k], paddr[k], rd_addr[k]});
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc = 0, first_rd = -1, first_valid = -1, last_acc = -1, done_cyc = -1;
        exp_t e, got;
        sb.delete(); push_frames(1, 1'b0);
        @(negedge clk); start[0] = 1'b1; ready[0] = 1'b1;
        while (done_cyc < 0 && cyc < 100) begin
            @(negedge clk); cyc++; start[0] = 1'b0;
            if (rd_en[0] && first_rd < 0) first_rd = cyc;
            if (valid[0] && first_valid < 0) first_valid = cyc;
            if (cyc == 1) begin
                n_tests++;
                if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b required 1", busy[0]); end
            end
            if (done[0]) begin
                done_cyc = cyc; n_tests++;
                if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b required 0", busy[0]); end
            end
            if (valid[0] && ready[0]) begin
                got = {data[0], paddr[0], hs[0], vs[0]}; n_tests++; last_acc = cyc;
                if (sb.size() == 0) begin n_fail++; $display("FAIL basic_extra_pixel got %h required none", got); end
                else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL basic_pixel got %h required %h", got, e); end
                end
            end
        end
        n_tests++; if (first_rd != 1) begin n_fail++; $display("FAIL basic_rd_latency got %0d required 1", first_rd); end
        n_tests++; if (first_valid != 3) begin n_fail++; $display("FAIL basic_valid_latency got %0d required 3", first_valid); end
        n_tests++; if (last_acc - first_valid != 11) begin n_fail++; $display("FAIL basic_throughput got %0d required 11", last_acc - first_valid); end
        n_tests++; if (done_cyc != last_acc + 1) begin n_fail++; $display("FAIL basic_done_cycle got %0d required %0d", done_cyc, last_acc + 1); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL basic_missing got %0d left required 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int cyc = 0, n_acc = 0, low_cnt = 0, outst = 0, max_outst = 0, last_acc = -1, done_cyc = -1;
        bit alt = 1'b1, held = 1'b0;
        exp_t e, got, held_val;
        sb.delete(); push_frames(1, 1'b0);
        @(negedge clk); start[0] = 1'b1; ready[0] = 1'b1;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk); cyc++; start[0] = 1'b0;
            if (n_acc < 3) ready[0] = 1'b1;
            else if (low_cnt < 5) begin ready[0] = 1'b0; low_cnt++; end
            else begin ready[0] = alt; alt = ~alt; end
            got = {data[0], paddr[0], hs[0], vs[0]};
            if (held) begin
                n_tests++; held = 1'b0;
                if ({valid[0], got} !== {1'b1, held_val}) begin
                    n_fail++; $display("FAIL bp_head_stable got %h required %h", {valid[0], got}, {1'b1, held_val});
                end
            end
            if (valid[0] && !ready[0]) begin held = 1'b1; held_val = got; end
            outst = outst + int'(rd_en[0]) - int'(valid[0] && ready[0]);
            if (outst > max_outst) max_outst = outst;
            if (done[0]) done_cyc = cyc;
            if (valid[0] && ready[0]) begin
                n_tests++; n_acc++; last_acc = cyc;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra_pixel got %h required none", got); end
                else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL bp_pixel got %h required %h", got, e); end
                end
            end
        end
        ready[0] = 1'b1;
        n_tests++; if (max_outst != 3) begin n_fail++; $display("FAIL bp_outstanding got %0d required 3", max_outst); end
        n_tests++; if (done_cyc != last_acc + 1) begin n_fail++; $display("FAIL bp_done_cycle got %0d required %0d", done_cyc, last_acc + 1); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_missing got %0d left required 0", sb.size()); end
    endtask

    task automatic test_blank();
        int cyc = 0, n_rd = 0, gap = 0, stray = 0, last_acc = -1, done_cyc = -1;
        bit gapping = 1'b0;
        exp_t e, got;
        sb.delete(); push_frames(1, 1'b0);
        @(negedge clk); start[1] = 1'b1; ready[1] = 1'b1;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk); cyc++; start[1] = 1'b0;
            if (rd_en[1]) begin
                if (gapping) begin
                    n_tests++; gapping = 1'b0;
                    if (gap != 2) begin n_fail++; $display("FAIL blank_gap after read %0d got %0d required 2", n_rd, gap); end
                end
                n_rd++;
                if (n_rd % 4 == 0 && n_rd < 12) begin gapping = 1'b1; gap = 0; end
            end else if (gapping) gap++;
            else if (n_rd > 0 && n_rd < 12) stray++;
            if (done[1]) done_cyc = cyc;
            if (valid[1] && ready[1]) begin
                got = {data[1], paddr[1], hs[1], vs[1]}; n_tests++; last_acc = cyc;
                if (sb.size() == 0) begin n_fail++; $display("FAIL blank_extra_pixel got %h required none", got); end
                else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL blank_pixel got %h required %h", got, e); end
                end
            end
        end
        n_tests++; if (n_rd != 12) begin n_fail++; $display("FAIL blank_reads got %0d required 12", n_rd); end
        n_tests++; if (stray != 0) begin n_fail++; $display("FAIL blank_stray_gaps got %0d required 0", stray); end
        n_tests++; if (done_cyc != last_acc + 1) begin n_fail++; $display("FAIL blank_done_cycle got %0d required %0d", done_cyc, last_acc + 1); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL blank_missing got %0d left required 0", sb.size()); end
    endtask

    task automatic test_multi_frame();
        int cyc = 0, n_vs = 0, n_done = 0, last_acc = -1, done_cyc = -1;
        exp_t e, got;
        sb.delete(); push_frames(2, 1'b0);
        @(negedge clk); start[2] = 1'b1; ready[2] = 1'b1;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk); cyc++;
            if (done[2]) begin done_cyc = cyc; n_done++; end
            if (valid[2] && ready[2]) begin
                got = {data[2], paddr[2], hs[2], vs[2]}; n_tests++; last_acc = cyc;
                if (vs[2]) n_vs++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL multi_extra_pixel got %h required none", got); end
                else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL multi_pixel got %h required %h", got, e); end
                end
            end
        end
        // start is still high through the done cycle and must be ignored there.
        @(negedge clk);
        n_tests++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL multi_start_in_done got busy %b required 0", busy[2]); end
        start[2] = 1'b0;
        @(negedge clk);
        if (done[2]) n_done++;
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL multi_done_pulses got %0d required 1", n_done); end
        n_tests++; if (n_vs != 2) begin n_fail++; $display("FAIL multi_vsync_count got %0d required 2", n_vs); end
        n_tests++; if (done_cyc != last_acc + 1) begin n_fail++; $display("FAIL multi_done_cycle got %0d required %0d", done_cyc, last_acc + 1); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL multi_missing got %0d left required 0", sb.size()); end
    endtask

    task automatic test_reset_midframe();
        int cyc = 0, n_acc = 0, last_acc = -1, done_cyc = -1;
        exp_t e, got;
        sb.delete(); push_frames(1, 1'b0);
        @(negedge clk); start[0] = 1'b1; ready[0] = 1'b1;
        while (n_acc < 5 && cyc < 100) begin
            @(negedge clk); cyc++; start[0] = 1'b0;
            if (valid[0] && ready[0]) begin
                got = {data[0], paddr[0], hs[0], vs[0]}; n_tests++; n_acc++;
                e = sb.pop_front();
                if (got !== e) begin n_fail++; $display("FAIL midreset_pre_pixel got %h required %h", got, e); end
            end
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rd_en[0], valid[0], hs[0], vs[0], busy[0], done[0], data[0], paddr[0], rd_addr[0]} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %h required 0",
                     {rd_en[0], valid[0], hs[0], vs[0], busy[0], done[0], data[0], paddr[0], rd_addr[0]});
        end
        reset = 1'b0;
        sb.delete(); push_frames(1, 1'b0);
        @(negedge clk); start[0] = 1'b1;
        cyc = 0;
        while (done_cyc < 0 && cyc < 100) begin
            @(negedge clk); cyc++; start[0] = 1'b0;
            if (done[0]) done_cyc = cyc;
            if (valid[0] && ready[0]) begin
                got = {data[0], paddr[0], hs[0], vs[0]}; n_tests++; last_acc = cyc;
                if (sb.size() == 0) begin n_fail++; $display("FAIL midreset_extra_pixel got %h required none", got); end
                else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL midreset_replay_pixel got %h required %h", got, e); end
                end
            end
        end
        n_tests++; if (done_cyc != last_acc + 1) begin n_fail++; $display("FAIL midreset_done_cycle got %0d required %0d", done_cyc, last_acc + 1); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL midreset_missing got %0d left required 0", sb.size()); end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        int cyc = 0, n_rd = 0, last_acc = -1, done_cyc = -1;
        exp_t e, got;
        sb.delete(); push_frames(1, 1'b1);
        @(negedge clk); start[0] = 1'b1; pat_sel[0] = 1'b1; ready[0] = 1'b1;
        while (done_cyc < 0 && cyc < 100) begin
            @(negedge clk); cyc++; start[0] = 1'b0; pat_sel[0] = 1'b0;
            if (rd_en[0]) n_rd++;
            if (done[0]) done_cyc = cyc;
            if (valid[0] && ready[0]) begin
                got = {data[0], paddr[0], hs[0], vs[0]}; n_tests++; last_acc = cyc;
                if (sb.size() == 0) begin n_fail++; $display("FAIL pattern_extra_pixel got %h required none", got); end
                else begin
                    e = sb.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL pattern_pixel got %h required %h", got, e); end
                end
            end
        end
        n_tests++; if (n_rd != 0) begin n_fail++; $display("FAIL pattern_mem_reads got %0d required 0", n_rd); end
        n_tests++; if (done_cyc != last_acc + 1) begin n_fail++; $display("FAIL pattern_done_cycle got %0d required %0d", done_cyc, last_acc + 1); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL pattern_missing got %0d left required 0", sb.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_blank();
        test_multi_frame();
        test_reset_midframe();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
